inv_mix_columns_iter: RTL and testbench

- Decryption-side counterpart of the encryption MixColumns stage. Applies AES InvMixColumns to a 128-bit state, one column per clock.
- Carries the round key and steps Rcon backwards: inverse xtime, so 0x1b→0x80, 0x80→0x40, …
- Sits between InvSubBytes/InvShiftRows and AddRoundKey in the decryption round pipeline.
- Uses a valid/ready handshake on both sides, so back-pressure from AddRoundKey stalls the block cleanly.

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/inv_mix_column_comb.sv | 29 ++
 rtl/inv_mix_columns_iter.sv | 121 ++++++++++++
 tb/tb_inv_mix_columns_iter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES helpers for the encryption and decryption round stages.
//   AES_POLY      : low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   xtime         : multiply by {02} in GF(2^8)
//   inv_xtime     : multiply by {02}^-1 in GF(2^8), used to step Rcon back
//   gmul9/11/13/14: constant multiplies needed by InvMixColumns
//   imc_state_e   : FSM states of the iterative InvMixColumns stage
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } imc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Undo xtime: an odd value must have had the polynomial folded in,
    // so remove it first and restore the shifted-out msb.
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        logic [7:0] r;
        if (x[0]) begin
            r = ((x ^ AES_POLY) >> 1) | 8'h80;
        end else begin
            r = x >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_column_comb.sv
// ---------------------------------------------------------------------------
// inv_mix_column_comb
// Purely combinational InvMixColumns on one 32-bit column.
//   col_i [31:0] : input column, byte a0 at [31:24] .. a3 at [7:0]
//   col_o [31:0] : output column, same byte order
// Row r uses the circulant coefficients {0e,0b,0d,09} rotated right by r.
// ---------------------------------------------------------------------------
module inv_mix_column_comb
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign a[gi] = col_i[31-8*gi -: 8];

            // b_r = e*a_r ^ b*a_(r+1) ^ d*a_(r+2) ^ 9*a_(r+3), indices mod 4
            assign col_o[31-8*gi -: 8] = gmul14(a[gi])
                                       ^ gmul11(a[(gi+1)%4])
                                       ^ gmul13(a[(gi+2)%4])
                                       ^ gmul9 (a[(gi+3)%4]);
        end
    endgenerate

endmodule

// File: rtl/inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_iter
// Iterative AES InvMixColumns stage for the decryption round pipeline.
// One column is transformed per clock through a single shared column unit.
// The round key is forwarded unchanged and Rcon is stepped backwards.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : upstream handshake for state_in, key_in, rcon_in
//   out_valid / out_ready : downstream handshake for state_out, key_out, rcon_out
//   state_in / state_out  : 128-bit state, byte0 at [127:120]
//   key_in / key_out      : round key, captured at accept
//   rcon_in / rcon_out    : round constant, rcon_out = inv_xtime(rcon_in)
//   busy                  : high while columns are being processed
// Accept at edge N gives out_valid after edge N+4; accepts are at least
// 6 cycles apart because the block never overlaps HOLD with a new accept.
// ---------------------------------------------------------------------------
module inv_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int NCOL = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [127:0] key_out,
    output logic [7:0]   rcon_out,
    output logic         busy
);

    localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

    imc_state_e        state_q;
    logic [1:0]        col_q;
    // Packed so that element NCOL-1 holds column 0 (bits [127:96]).
    logic [3:0][31:0]  work_q;
    logic [3:0][31:0]  work_d;
    logic [127:0]      state_out_q;
    logic [127:0]      key_out_q;
    logic [7:0]        rcon_out_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [31:0]       col_cur;
    logic [31:0]       col_mix;

    assign col_cur = work_q[LAST_COL - col_q];

    inv_mix_column_comb u_col (
        .col_i (col_cur),
        .col_o (col_mix)
    );

    always_comb begin
        work_d = work_q;
        work_d[LAST_COL - col_q] = col_mix;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            work_q      <= '0;
            state_out_q <= '0;
            key_out_q   <= '0;
            rcon_out_q  <= 8'h00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= state_in;
                        key_out_q  <= key_in;
                        rcon_out_q <= inv_xtime(rcon_in);
                        col_q      <= 2'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    work_q <= work_d;
                    col_q  <= col_q + 2'd1;
                    if (col_q == LAST_COL) begin
                        // Publish the state including the column finished this cycle.
                        state_out_q <= work_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = state_out_q;
    assign key_out   = key_out_q;
    assign rcon_out  = rcon_out_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_columns_iter
// Self-checking bench for inv_mix_columns_iter. Expected values come from
// constant tables and from a matrix-times-column GF(2^8) reference model.
// ---------------------------------------------------------------------------
module tb_inv_mix_columns_iter;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic [7:0]   rcon_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [127:0] key_out;
    logic [7:0]   rcon_out;
    logic         busy;

    int total = 0;
    int bad   = 0;

    inv_mix_columns_iter #(.NCOL(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .key_in    (key_in),
        .rcon_in   (rcon_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .key_out   (key_out),
        .rcon_out  (rcon_out),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Column-wise matrix product with a circulant coefficient row.
    function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inverse);
        logic [7:0]   co [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inverse) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else         co = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(co[(k - row + 4) % 4], s[127-8*(4*c+k) -: 8]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Rcon stepped back = the unique x with x*{02} == r.
    function automatic logic [7:0] rcon_model(input logic [7:0] r);
        logic [7:0] res;
        res = 8'h00;
        for (int x = 0; x < 256; x++)
            if (gf_mul(8'(x), 8'h02) == r) res = 8'(x);
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full transaction from IDLE: accept, wait, capture, handshake.
    task automatic do_txn(input logic [127:0] s, input logic [127:0] k, input logic [7:0] r,
                          output logic [127:0] so, output logic [127:0] ko,
                          output logic [7:0] ro, output int lat);
        state_in = s;
        key_in   = k;
        rcon_in  = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        so = state_out;
        ko = key_out;
        ro = rcon_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", {127'd0, out_valid}, 128'd0);
        check("release_in_ready",  {127'd0, in_ready},  128'd1);
        $display("txn state_in=%h rcon_in=%h -> state_out=%h rcon_out=%h lat=%0d", s, r, so, ro, lat);
    endtask

    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        logic [7:0]   rc;
        logic [127:0] exp_st;
        logic [7:0]   exp_rc;
    } vec_t;

    vec_t         vecs [4];
    logic [127:0] so, ko, s, k, m, snap;
    logic [7:0]   ro, rc, snap_rc;
    int           lat;
    logic [7:0]   chain_exp [9];
    logic [127:0] exp_q [$];
    logic [127:0] key_q [$];

    initial begin
        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h00010203_04050607_08090a0b_0c0d0e0f,
                    8'h36, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 8'h1b};
        vecs[1] = '{128'h0, {4{32'hffffffff}}, 8'h01, 128'h0, 8'h8d};
        vecs[2] = '{{4{32'h01010101}}, 128'h11223344_55667788_99aabbcc_ddeeff00, 8'h1b,
                    {4{32'h01010101}}, 8'h80};
        vecs[3] = '{128'hc6c6c6c6_01010101_8e4da1bc_9fdc589d, 128'hdeadbeef_01234567_89abcdef_cafef00d,
                    8'h80, 128'hc6c6c6c6_01010101_db135345_f20a225c, 8'h40};
        chain_exp = '{8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        key_in    = '0;
        rcon_in   = 8'h00;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_in_ready",  {127'd0, in_ready},  128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_busy",      {127'd0, busy},      128'd0);
        check("rst_state_out", state_out, 128'd0);
        check("rst_key_out",   key_out,   128'd0);
        check("rst_rcon_out",  {120'd0, rcon_out}, 128'd0);
        reset = 1'b0;
        tick();

        // ---- table vectors ----
        for (int i = 0; i < 4; i++) begin
            do_txn(vecs[i].st, vecs[i].key, vecs[i].rc, so, ko, ro, lat);
            check("vec_state", so, vecs[i].exp_st);
            check("vec_key",   ko, vecs[i].key);
            check("vec_rcon",  {120'd0, ro}, {120'd0, vecs[i].exp_rc});
            check("vec_latency", 128'(lat), 128'd4);
        end

        // ---- rcon chain from 0x36 ----
        rc = 8'h36;
        for (int i = 0; i < 9; i++) begin
            s = rand128();
            k = rand128();
            do_txn(s, k, rc, so, ko, ro, lat);
            check("chain_rcon",  {120'd0, ro}, {120'd0, chain_exp[i]});
            check("chain_model", {120'd0, ro}, {120'd0, rcon_model(rc)});
            check("chain_state", so, mix_model(s, 1'b1));
            check("chain_key",   ko, k);
            rc = ro;
        end

        // ---- back-pressure in HOLD ----
        s = rand128();
        k = rand128();
        state_in = s;
        key_in   = k;
        rcon_in  = 8'h10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_latency", 128'(lat), 128'd4);
        snap    = state_out;
        snap_rc = rcon_out;
        check("bp_state", snap, mix_model(s, 1'b1));
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                state_in = rand128();
                key_in   = rand128();
                rcon_in  = 8'h55;
                in_valid = 1'b1;
            end
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
            check("bp_in_ready",  {127'd0, in_ready},  128'd0);
            check("bp_stable",    state_out, snap);
            tick();
        end
        in_valid = 1'b0;
        check("bp_rcon_kept", {120'd0, rcon_out}, {120'd0, snap_rc});
        check("bp_key_kept",  key_out, k);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", {127'd0, out_valid}, 128'd0);
        check("bp_release_ready", {127'd0, in_ready},  128'd1);
        tick();
        check("bp_no_accept", {127'd0, busy}, 128'd0);
        $display("txn backpressure state_out=%h", snap);

        // ---- reset in the middle of COMPUTE ----
        state_in = rand128();
        key_in   = rand128();
        rcon_in  = 8'h20;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", {127'd0, busy}, 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_in_ready",  {127'd0, in_ready},  128'd1);
        check("mid_out_valid", {127'd0, out_valid}, 128'd0);
        check("mid_busy_clr",  {127'd0, busy},      128'd0);
        check("mid_state_out", state_out, 128'd0);
        check("mid_key_out",   key_out,   128'd0);
        check("mid_rcon_out",  {120'd0, rcon_out}, 128'd0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) lat++;
            tick();
        end
        check("mid_no_output", 128'(lat), 128'd0);
        $display("txn reset-mid-compute");
        s = rand128();
        k = rand128();
        do_txn(s, k, 8'h04, so, ko, ro, lat);
        check("post_rst_state", so, mix_model(s, 1'b1));
        check("post_rst_rcon",  {120'd0, ro}, 128'h02);

        // ---- round trip: forward MixColumns then this block ----
        for (int i = 0; i < 1000; i++) begin
            s  = rand128();
            k  = rand128();
            rc = 8'($urandom);
            m  = mix_model(s, 1'b0);
            do_txn(m, k, rc, so, ko, ro, lat);
            check("rt_state", so, s);
            check("rt_rcon",  {120'd0, ro}, {120'd0, rcon_model(rc)});
            check("rt_key",   ko, k);
        end

        // ---- back-to-back with in_valid and out_ready held high ----
        begin
            int n_acc;
            int n_out;
            int cyc;
            int last_acc;
            bit acc;
            bit xfer;
            n_acc    = 0;
            n_out    = 0;
            cyc      = 0;
            last_acc = -1;
            state_in = rand128();
            key_in   = rand128();
            in_valid = 1'b1;
            out_ready = 1'b1;
            while (n_out < 50 && cyc < 2000) begin
                acc  = in_valid && in_ready;
                xfer = out_valid && out_ready;
                if (xfer) begin
                    if (exp_q.size() == 0) begin
                        check("b2b_spurious", {127'd0, out_valid}, 128'd0);
                    end else begin
                        check("b2b_state", state_out, exp_q.pop_front());
                        check("b2b_key",   key_out,   key_q.pop_front());
                    end
                    n_out++;
                    $display("txn b2b out=%0d state_out=%h", n_out, state_out);
                    if (n_out == 50) in_valid = 1'b0;
                end
                if (acc) begin
                    exp_q.push_back(mix_model(state_in, 1'b1));
                    key_q.push_back(key_in);
                    if (last_acc >= 0) check("b2b_spacing", 128'(cyc - last_acc), 128'd6);
                    last_acc = cyc;
                    n_acc++;
                end
                tick();
                cyc++;
                if (acc) begin
                    state_in = rand128();
                    key_in   = rand128();
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("b2b_outputs", 128'(n_out), 128'd50);
            check("b2b_accepts", 128'(n_acc), 128'd50);
            check("b2b_pending", 128'(exp_q.size()), 128'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
